prbs_frame_tx: RTL and testbench
================================

// Module: prbs_frame_tx
// PURPOSE
//  Single-clock, multi-channel test-pattern frame transmitter: generator plus serialiser in one block.
//  A send_enable pulse emits one frame of FRAME_WORDS x DATA_WIDTH bits per channel at a programmable bit rate.
//  Bit rate is f_clk/(speedctr+1). Pattern modes: PRBS, clock pattern, all-ones, word counter.
//  Sits between the debounced send pulse and the output pins/OBUFDS of the color-filter test bench.
// PARAMETERS
//  NUM_CH       1   serial output channels
//  DATA_WIDTH   10  bits per word
//  FRAME_WORDS  20  payload words per frame (>=1)
//  POLY_LENGTH  9   LFSR length n, polynomial x^n + x^t + 1
//  POLY_TAP     5   LFSR tap t (1..n-1)
//  INV_PATTERN  1   1: invert payload bits (all modes) before output
// PORTS
//  clk          in   1                 single system clock
//  rst          in   1                 synchronous, active-high reset
//  send_enable  in   1                 1-cycle start pulse
//  speedctr     in   4                 bit period = speedctr+1 clk cycles
//  mode         in   2                 0 PRBS, 1 1010.., 2 all-ones, 3 word counter
//  busy         out  1                 frame in progress
//  bit_strobe   out  1                 high on first clk of every bit period
//  frame_done   out  1                 1-cycle pulse after last bit period
//  serial_out   out  NUM_CH            serial data, MSB of each word first
// BEHAVIOUR
//  Reset values: busy=0, bit_strobe=0, frame_done=0, serial_out=0; FSM=IDLE; LFSRs=seed.
//  FSM IDLE -> SEND (send_enable & ~busy) -> DONE (last bit period ends) -> IDLE (next cycle).
//  Start: send_enable at edge t => busy=1, bit_strobe=1, first bit on serial_out from edge t+1.
//  speedctr and mode are latched at start; changes mid-frame have no effect.
//  Each bit is held exactly speedctr+1 cycles; divider counts 0..speedctr, wrap = next bit.
//  Frame length = FRAME_WORDS*DATA_WIDTH bit periods (+ preamble word, see CONFIGURATION).
//  DONE cycle: busy=0, frame_done=1, serial_out=0. send_enable in DONE is ignored.
//  send_enable while busy: ignored, no queueing. Next frame needs a fresh pulse in IDLE.
//  PRBS: Fibonacci LFSR per channel c, seed = {n{1'b1}} ^ c, reseeded at every frame start.
//   out bit = lfsr[n-1]; step once per bit period: lfsr <= {lfsr[n-2:0], lfsr[n-1]^lfsr[t-1]}.
//   Frames are therefore bit-identical.
//  Mode 1: bit k of frame = ~k[0] (first bit 1). Mode 2: all 1.
//  Mode 3: word index w (0..FRAME_WORDS-1) mod 2^DATA_WIDTH, MSB first, same on all channels.
//  INV_PATTERN applies to payload only, not to preamble or idle level.
//  Counters: bit-in-word 0..DATA_WIDTH-1 wraps into word counter 0..FRAME_WORDS-1; widths via $clog2.
//  rst mid-frame: next edge returns all outputs to reset values and FSM to IDLE. No frame_done pulse.
//  rst and send_enable on the same edge: rst wins.
// CONFIGURATION
//  PREAMBLE_EN defined: one DATA_WIDTH preamble word of 1010.. (MSB=1) is sent first on every channel.
//   During the preamble the LFSR and word counter do not advance.
//   Frame = (FRAME_WORDS+1)*DATA_WIDTH bit periods.
//  PREAMBLE_EN undefined: payload starts at the first bit; no preamble logic is present.
// TESTING
//  1 Reset: rst high 3 cycles, send_enable pulsed -> all outputs 0, busy stays 0.
//  2 PRBS, NUM_CH=1, speedctr=0, INV_PATTERN=0, FRAME_WORDS=2:
//    -> 20 bits, first 9 are 1, then PRBS9 sequence; frame_done at cycle 21; two frames identical.
//  3 Mode 2, speedctr=3 -> busy high exactly 80 cycles; bit_strobe every 4th cycle (20 strobes).
//  4 Mode 3, DATA_WIDTH=10, INV_PATTERN=1 -> word0 = 1111111111, word1 = 1111111110.
//  5 send_enable re-pulsed mid-frame and speedctr changed 0->7 mid-frame -> ignored; length unchanged.
//  6 rst at bit 7 of the frame -> next cycle busy=0, serial_out=0, no frame_done;
//    next send_enable restarts from seed.
//  7 PREAMBLE_EN, speedctr=0 -> first 10 bits 1010101010, then the same payload as case 2.
//  8 NUM_CH=2, PRBS -> ch1 starts from seed 0x1FE and differs from ch0.

Source files
------------

// File: rtl/prbs_frame_tx.sv
// Multi-channel test-pattern frame generator and serialiser (PRBS, clock, all-ones, word counter).
// Define PREAMBLE_EN to prepend one 1010.. preamble word to every frame.
module prbs_frame_tx #(
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned FRAME_WORDS = 20,
  parameter int unsigned POLY_LENGTH = 9,
  parameter int unsigned POLY_TAP    = 5,
  parameter bit          INV_PATTERN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_enable,
  input  logic [3:0]        speedctr,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              bit_strobe,
  output logic              frame_done,
  output logic [NUM_CH-1:0] serial_out
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned N  = POLY_LENGTH;

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;
  typedef logic [N-1:0] lfsr_t;

  state_e              state_q;
  logic [3:0]          spd_q, div_q;
  logic [1:0]          mode_q, mode_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [WW-1:0]       word_q, word_d;
  logic                phase_q, phase_d;
  lfsr_t               lfsr_q [NUM_CH];
  lfsr_t               lfsr_d [NUM_CH];
  logic                in_pre, pre_d;
  logic [NUM_CH-1:0]   pat_d;
  logic [DATA_WIDTH-1:0] wval;
  logic                start, period_end, wrap, last_bit, adv;

  function automatic lfsr_t seed(input int unsigned c);
    return {N{1'b1}} ^ lfsr_t'(c);
  endfunction

  function automatic lfsr_t step(input lfsr_t l);
    return {l[N-2:0], l[N-1] ^ l[POLY_TAP-1]};
  endfunction

`ifdef PREAMBLE_EN
  localparam bit PreStart = 1'b1;
  logic pre_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= 1'b0;
    end else if (adv) begin
      pre_q <= pre_d;
    end
  end
  assign in_pre = pre_q;
`else
  localparam bit PreStart = 1'b0;
  assign in_pre = 1'b0;
`endif

  // Everything below describes the position the *next* bit period will show, so outputs register
  // straight from it and appear the cycle after the start/period-end edge.
  always_comb begin
    start      = (state_q == StIdle) && send_enable;
    period_end = (div_q == spd_q);
    wrap       = (bit_q == BW'(DATA_WIDTH - 1));
    last_bit   = !in_pre && wrap && (word_q == WW'(FRAME_WORDS - 1));
    adv        = start || ((state_q == StSend) && period_end && !last_bit);
    mode_d     = start ? mode : mode_q;
    if (start) begin
      bit_d   = '0;
      word_d  = '0;
      phase_d = 1'b0;
      pre_d   = PreStart;
    end else begin
      bit_d   = wrap ? '0 : bit_q + BW'(1);
      word_d  = (!in_pre && wrap) ? word_q + WW'(1) : word_q;
      phase_d = in_pre ? phase_q : ~phase_q;
      pre_d   = in_pre && !wrap;
    end
    wval = DATA_WIDTH'(word_d);
    for (int c = 0; c < NUM_CH; c++) begin
      lfsr_d[c] = start ? seed(c) : (in_pre ? lfsr_q[c] : step(lfsr_q[c]));
      if (pre_d) begin
        pat_d[c] = ~bit_d[0];
      end else begin
        unique case (mode_d)
          2'd0:    pat_d[c] = lfsr_d[c][N-1];
          2'd1:    pat_d[c] = ~phase_d;
          2'd2:    pat_d[c] = 1'b1;
          default: pat_d[c] = wval[BW'(DATA_WIDTH - 1) - bit_d];
        endcase
        pat_d[c] = pat_d[c] ^ INV_PATTERN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
      serial_out <= '0;
      spd_q      <= '0;
      div_q      <= '0;
      mode_q     <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      phase_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) lfsr_q[c] <= seed(c);
    end else begin
      if (adv) begin
        bit_q      <= bit_d;
        word_q     <= word_d;
        phase_q    <= phase_d;
        mode_q     <= mode_d;
        lfsr_q     <= lfsr_d;
        div_q      <= '0;
        bit_strobe <= 1'b1;
        serial_out <= pat_d;
      end
      unique case (state_q)
        StIdle: begin
          frame_done <= 1'b0;
          if (start) begin
            state_q <= StSend;
            busy    <= 1'b1;
            spd_q   <= speedctr;
          end
        end
        StSend: begin
          if (!period_end) begin
            div_q      <= div_q + 4'd1;
            bit_strobe <= 1'b0;
          end else if (last_bit) begin
            state_q    <= StDone;
            busy       <= 1'b0;
            bit_strobe <= 1'b0;
            frame_done <= 1'b1;
            serial_out <= '0;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          frame_done <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_prbs_frame_tx.sv
// Self-checking bench for prbs_frame_tx: directed and random frames against a bit-list model.
module tb_prbs_frame_tx;

  localparam int NCH = 2;
  localparam int DW  = 10;
  localparam int FW  = 2;
  localparam int PN  = 9;
  localparam int PT  = 5;
  localparam bit INV = 1'b1;
`ifdef PREAMBLE_EN
  localparam int PRE = 1;
`else
  localparam int PRE = 0;
`endif
  localparam int NBITS = (FW + PRE) * DW;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           send_enable = 1'b0;
  logic [3:0]     speedctr = 4'd0;
  logic [1:0]     mode = 2'd0;
  logic           busy, bit_strobe, frame_done;
  logic [NCH-1:0] serial_out;

  int n_checks = 0;
  int n_fails  = 0;
  bit exp_bits [NBITS][NCH];

  always #5 clk = ~clk;

  prbs_frame_tx #(
    .NUM_CH      (NCH),
    .DATA_WIDTH  (DW),
    .FRAME_WORDS (FW),
    .POLY_LENGTH (PN),
    .POLY_TAP    (PT),
    .INV_PATTERN (INV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send_enable (send_enable),
    .speedctr    (speedctr),
    .mode        (mode),
    .busy        (busy),
    .bit_strobe  (bit_strobe),
    .frame_done  (frame_done),
    .serial_out  (serial_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected frame as a flat list of bits per channel, straight from the pattern definitions.
  task automatic build_model(input logic [1:0] m);
    int s, p, w;
    bit b;
    for (int c = 0; c < NCH; c++) begin
      s = ((1 << PN) - 1) ^ c;
      for (int k = 0; k < NBITS; k++) begin
        p = k - PRE * DW;
        if (p < 0) begin
          b = (k % 2 == 0);
        end else begin
          case (m)
            2'd0:    b = bit'((s >> (PN - 1)) & 1);
            2'd1:    b = (p % 2 == 0);
            2'd2:    b = 1'b1;
            default: begin
              w = (p / DW) % (1 << DW);
              b = bit'((w >> (DW - 1 - p % DW)) & 1);
            end
          endcase
          b = b ^ INV;
          s = ((s << 1) | (((s >> (PN - 1)) ^ (s >> (PT - 1))) & 1)) & ((1 << PN) - 1);
        end
        exp_bits[k][c] = b;
      end
    end
  endtask

  function automatic logic [NCH-1:0] exp_vec(input int k);
    logic [NCH-1:0] e;
    for (int c = 0; c < NCH; c++) e[c] = exp_bits[k][c];
    return e;
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic run_frame(input logic [1:0] m, input logic [3:0] s, input bit disturb);
    int per;
    build_model(m);
    per = int'(s) + 1;
    mode = m;
    speedctr = s;
    send_enable = 1'b1;
    @(negedge clk);
    send_enable = 1'b0;
    for (int cyc = 0; cyc < NBITS * per; cyc++) begin
      check("busy", 32'(busy), 32'(1));
      check("bit_strobe", 32'(bit_strobe), 32'(cyc % per == 0));
      check("serial_out", 32'(serial_out), 32'(exp_vec(cyc / per)));
      check("frame_done_mid", 32'(frame_done), 32'(0));
      if (disturb && cyc == 3) begin
        send_enable = 1'b1;
        speedctr = 4'd7;
        mode = m + 2'd1;
      end else begin
        send_enable = 1'b0;
      end
      @(negedge clk);
    end
    check("done_busy", 32'(busy), 32'(0));
    check("done_pulse", 32'(frame_done), 32'(1));
    check("done_serial", 32'(serial_out), 32'(0));
    @(negedge clk);
    check("after_done", 32'(frame_done), 32'(0));
    check("after_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    // Reset with a send pulse colliding: reset must win.
    @(negedge clk);
    send_enable = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_strobe", 32'(bit_strobe), 32'(0));
    check("rst_done", 32'(frame_done), 32'(0));
    check("rst_serial", 32'(serial_out), 32'(0));
    send_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'(0));

    // PRBS twice: frames must be identical (model reseeds each time).
    run_frame(2'd0, 4'd0, 1'b0);
    run_frame(2'd0, 4'd0, 1'b0);
    run_frame(2'd2, 4'd3, 1'b0);
    run_frame(2'd3, 4'd0, 1'b0);
    run_frame(2'd1, 4'd1, 1'b0);
    // Re-pulse and speed/mode change mid-frame are ignored.
    run_frame(2'd0, 4'd0, 1'b1);

    // Reset on bit 7 of a frame.
    build_model(2'd0);
    mode = 2'd0;
    speedctr = 4'd0;
    send_enable = 1'b1;
    @(negedge clk);
    send_enable = 1'b0;
    repeat (7) @(negedge clk);
    check("bit7_serial", 32'(serial_out), 32'(exp_vec(7)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_serial", 32'(serial_out), 32'(0));
    check("midrst_strobe", 32'(bit_strobe), 32'(0));
    check("midrst_done", 32'(frame_done), 32'(0));
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", 32'(frame_done), 32'(0));
      check("midrst_idle", 32'(busy), 32'(0));
    end
    run_frame(2'd0, 4'd0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_frame(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
